cp0_issue_sched: RTL and testbench

- Sits between the two-slot MEM/WB boundary of the dual-issue pipeline and the CP0 register file.
- Arbitrates which slot's exception, MTC0 or MFC0 info reaches CP0's single-slot interface.
- Serialises slot pairs that CP0 cannot absorb in one cycle.
- Captures per-slot MFC0 read data.
- Sequences the post-exception flush/redirect handshake toward fetch.

---
 rtl/cp0_issue_sched_pkg.sv | 25 ++
 rtl/cp0_issue_sched_slot_latch.sv | 18 +
 rtl/cp0_issue_sched.sv | 101 ++++++++++
 tb/tb_cp0_issue_sched.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_issue_sched_pkg.sv
// cp0_issue_sched_pkg: shared bundle layout, state encoding and slot record for the CP0 issue scheduler
package cp0_issue_sched_pkg;
  localparam int EXCEPT_WD = 44;
  localparam int WE_BIT = 42;
  localparam int RADDR_LSB = 32;
  localparam logic [31:0] ZeroWord = 32'h0;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SECOND   = 2'd1,
    REDIRECT = 2'd2,
    DRAIN    = 2'd3
  } state_t;
  typedef struct packed {
    logic [EXCEPT_WD-1:0] info;
    logic [31:0]          pc;
    logic [31:0]          wdata;
    logic [31:0]          bad_addr;
  } slot_t;
  function automatic logic is_ex(input slot_t s);
    return s.info[31:0] != ZeroWord;
  endfunction
  function automatic logic is_acc(input slot_t s);
    return s.info[WE_BIT] || (s.info[RADDR_LSB+:5] != 5'd0);
  endfunction
endpackage

// File: rtl/cp0_issue_sched_slot_latch.sv
// cp0_issue_sched_slot_latch: holds the deferred younger slot while CP0 serves the older one
module cp0_issue_sched_slot_latch
  import cp0_issue_sched_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_load,
  input  logic  i_clear,
  input  slot_t i_slot,
  output slot_t o_slot
);
  slot_t r_slot;
  // capture on load, drop on clear or reset
  always_ff @(posedge clk)
    if (rst || i_clear) r_slot <= '0;
    else if (i_load) r_slot <= i_slot;
  assign o_slot = r_slot;
endmodule

// File: rtl/cp0_issue_sched.sv
// cp0_issue_sched: funnels a dual-issue MEM/WB pair into CP0's single slot and sequences flush/redirect
module cp0_issue_sched
  import cp0_issue_sched_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i1,
  input  logic                 valid_i2,
  input  logic [EXCEPT_WD-1:0] exceptinfo_i1,
  input  logic [EXCEPT_WD-1:0] exceptinfo_i2,
  input  logic [31:0]          pc_i1,
  input  logic [31:0]          pc_i2,
  input  logic [31:0]          rt_rdata_i1,
  input  logic [31:0]          rt_rdata_i2,
  input  logic [31:0]          bad_addr_i1,
  input  logic [31:0]          bad_addr_i2,
  output logic [EXCEPT_WD-1:0] cp0_exceptinfo_o,
  output logic [31:0]          cp0_pc_o,
  output logic [31:0]          cp0_wdata_o,
  output logic [31:0]          cp0_bad_addr_o,
  input  logic [31:0]          cp0_rdata_i,
  input  logic                 cp0_flush_i,
  input  logic [31:0]          cp0_new_pc_i,
  output logic [31:0]          rdata_o1,
  output logic [31:0]          rdata_o2,
  output logic                 stall_o,
  output logic                 flush_o,
  output logic                 redirect_valid_o,
  output logic [31:0]          redirect_pc_o,
  input  logic                 redirect_ready_i
);
  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [31:0] r_new_pc;
  logic [31:0] r_rdata1;
  logic [31:0] r_rdata2;
  slot_t       w_s1, w_s2, w_pend, w_fwd;
  logic        w_sel1, w_sel2, w_pair, w_live, w_to2, w_rd;
  // qualify both slots and pick the single one CP0 sees this cycle
  always_comb begin
    w_s1   = valid_i1 ? {exceptinfo_i1, pc_i1, rt_rdata_i1, bad_addr_i1} : '0;
    w_s2   = valid_i2 ? {exceptinfo_i2, pc_i2, rt_rdata_i2, bad_addr_i2} : '0;
    w_sel1 = is_ex(w_s1) || is_acc(w_s1);
    w_sel2 = is_ex(w_s2) || is_acc(w_s2);
    w_live = (r_state == IDLE) || (r_state == SECOND);
    w_pair = (r_state == IDLE) && !is_ex(w_s1) && is_acc(w_s1) && w_sel2;
    w_fwd  = !w_live ? '0 :
             (r_state == SECOND) ? w_pend :
             w_sel1 ? w_s1 :
             w_sel2 ? w_s2 : {{EXCEPT_WD{1'b0}}, pc_i1, ZeroWord, ZeroWord};
    w_to2  = (r_state == SECOND) || !w_sel1;
    w_rd   = w_live && (w_fwd.info[RADDR_LSB+:5] != 5'd0);
  end
  cp0_issue_sched_slot_latch u_slot2 (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_pair),
    .i_clear (w_live && cp0_flush_i),
    .i_slot  (w_s2),
    .o_slot  (w_pend)
  );
  // state sequencing, redirect target capture and per-slot MFC0 result capture
  always_ff @(posedge clk)
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= 3'd0;
      r_new_pc <= ZeroWord;
      r_rdata1 <= ZeroWord;
      r_rdata2 <= ZeroWord;
    end else begin
      if (w_rd && !w_to2) r_rdata1 <= cp0_rdata_i;
      if (w_rd && w_to2) r_rdata2 <= cp0_rdata_i;
      case (r_state)
        IDLE, SECOND:
          if (cp0_flush_i) begin
            r_state  <= REDIRECT;
            r_new_pc <= cp0_new_pc_i;
          end else r_state <= w_pair ? SECOND : IDLE;
        REDIRECT:
          if (redirect_ready_i) begin
            r_state <= DRAIN;
            r_cnt   <= 3'(DRAIN_CYCLES - 1);
          end
        DRAIN:
          if (r_cnt == 3'd0) r_state <= IDLE;
          else r_cnt <= r_cnt - 3'd1;
      endcase
    end
  assign cp0_exceptinfo_o = w_fwd.info;
  assign cp0_pc_o         = w_fwd.pc;
  assign cp0_wdata_o      = w_fwd.wdata;
  assign cp0_bad_addr_o   = w_fwd.bad_addr;
  assign rdata_o1         = r_rdata1;
  assign rdata_o2         = r_rdata2;
  assign stall_o          = w_pair;
  assign flush_o          = !w_live;
  assign redirect_valid_o = r_state == REDIRECT;
  assign redirect_pc_o    = redirect_valid_o ? r_new_pc : ZeroWord;
endmodule

// File: tb/tb_cp0_issue_sched.sv
// tb_cp0_issue_sched: directed and random checks of the CP0 issue scheduler against a cycle reference model
module tb_cp0_issue_sched;
  localparam int DRAIN = 2;
  logic clk = 1'b0;
  logic rst;
  logic valid_i1, valid_i2;
  logic [43:0] exceptinfo_i1, exceptinfo_i2, cp0_exceptinfo_o;
  logic [31:0] pc_i1, pc_i2, rt_rdata_i1, rt_rdata_i2, bad_addr_i1, bad_addr_i2;
  logic [31:0] cp0_pc_o, cp0_wdata_o, cp0_bad_addr_o, cp0_rdata_i, cp0_new_pc_i;
  logic [31:0] rdata_o1, rdata_o2, redirect_pc_o;
  logic cp0_flush_i, stall_o, flush_o, redirect_valid_o, redirect_ready_i;
  int total = 0, passed = 0, fails = 0;
  bit m_pend, m_redir;
  int m_drain;
  logic [43:0] mp_info;
  logic [31:0] mp_pc, mp_wd, mp_ba, m_npc, m_rd1, m_rd2;

  cp0_issue_sched #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst), .valid_i1(valid_i1), .valid_i2(valid_i2),
    .exceptinfo_i1(exceptinfo_i1), .exceptinfo_i2(exceptinfo_i2),
    .pc_i1(pc_i1), .pc_i2(pc_i2), .rt_rdata_i1(rt_rdata_i1), .rt_rdata_i2(rt_rdata_i2),
    .bad_addr_i1(bad_addr_i1), .bad_addr_i2(bad_addr_i2),
    .cp0_exceptinfo_o(cp0_exceptinfo_o), .cp0_pc_o(cp0_pc_o), .cp0_wdata_o(cp0_wdata_o),
    .cp0_bad_addr_o(cp0_bad_addr_o), .cp0_rdata_i(cp0_rdata_i), .cp0_flush_i(cp0_flush_i),
    .cp0_new_pc_i(cp0_new_pc_i), .rdata_o1(rdata_o1), .rdata_o2(rdata_o2),
    .stall_o(stall_o), .flush_o(flush_o), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o), .redirect_ready_i(redirect_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [43:0] mk(input logic we, input logic [4:0] wa, input logic [4:0] ra, input logic [31:0] exc);
    return {1'b0, we, wa, ra, exc};
  endfunction

  function automatic logic [43:0] rnd_info();
    logic [31:0] exc;
    logic [4:0] ra, wa;
    logic we;
    exc = ($urandom_range(0, 5) == 0) ? $urandom : 32'h0;
    we  = $urandom_range(0, 3) == 0;
    wa  = 5'($urandom);
    ra  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
    return {1'($urandom), we, wa, ra, exc};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr();
    valid_i1 = 0; valid_i2 = 0; exceptinfo_i1 = '0; exceptinfo_i2 = '0;
    pc_i1 = '0; pc_i2 = '0; rt_rdata_i1 = '0; rt_rdata_i2 = '0;
    bad_addr_i1 = '0; bad_addr_i2 = '0; cp0_rdata_i = '0; cp0_flush_i = 0;
    cp0_new_pc_i = '0; redirect_ready_i = 0;
  endtask

  // one cycle: predict outputs from the rules, compare, advance the model, cross the edge
  task automatic tick();
    logic [43:0] i1, i2, ei;
    logic [31:0] epc, ewd, eba;
    logic x1, a1, x2, a2, est, efl, erv, to2;
    #1;
    i1 = valid_i1 ? exceptinfo_i1 : '0;
    i2 = valid_i2 ? exceptinfo_i2 : '0;
    x1 = i1[31:0] != 0; a1 = i1[42] || i1[36:32] != 0;
    x2 = i2[31:0] != 0; a2 = i2[42] || i2[36:32] != 0;
    est = 0; to2 = 0;
    efl = m_redir || m_drain > 0;
    erv = m_redir;
    if (efl) {ei, epc, ewd, eba} = '0;
    else if (m_pend) begin
      {ei, epc, ewd, eba} = {mp_info, mp_pc, mp_wd, mp_ba};
      to2 = 1;
    end else if (x1 || a1) begin
      {ei, epc, ewd, eba} = {i1, pc_i1, rt_rdata_i1, bad_addr_i1};
      est = !x1 && (x2 || a2);
    end else if (x2 || a2) begin
      {ei, epc, ewd, eba} = {i2, pc_i2, rt_rdata_i2, bad_addr_i2};
      to2 = 1;
    end else {ei, epc, ewd, eba} = {44'h0, pc_i1, 64'h0};
    if (!rst) begin
      chk("exceptinfo", cp0_exceptinfo_o, ei);
      chk("cp0_pc", cp0_pc_o, epc);
      chk("wdata", cp0_wdata_o, ewd);
      chk("bad_addr", cp0_bad_addr_o, eba);
      chk("stall", stall_o, est);
      chk("flush", flush_o, efl);
      chk("redir_valid", redirect_valid_o, erv);
      chk("redir_pc", redirect_pc_o, erv ? m_npc : 32'h0);
      chk("rdata1", rdata_o1, m_rd1);
      chk("rdata2", rdata_o2, m_rd2);
    end
    if (rst) begin
      m_pend = 0; m_redir = 0; m_drain = 0; m_npc = 0; m_rd1 = 0; m_rd2 = 0;
    end else if (m_redir) begin
      if (redirect_ready_i) begin m_redir = 0; m_drain = DRAIN; end
    end else if (m_drain > 0) m_drain--;
    else begin
      if (ei[36:32] != 0) begin
        if (to2) m_rd2 = cp0_rdata_i; else m_rd1 = cp0_rdata_i;
      end
      if (cp0_flush_i) begin m_redir = 1; m_npc = cp0_new_pc_i; m_pend = 0; end
      else if (est) begin m_pend = 1; {mp_info, mp_pc, mp_wd, mp_ba} = {i2, pc_i2, rt_rdata_i2, bad_addr_i2}; end
      else m_pend = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rv_cnt, fl_cnt;
    clr();
    rst = 1;
    @(posedge clk);
    #1;
    tick();
    rst = 0;
    #1;
    chk("rst_stall", stall_o, 0);
    chk("rst_flush", flush_o, 0);
    chk("rst_rv", redirect_valid_o, 0);
    tick();
    // MTC0 Status then MFC0 Status: serialised, slot 2 sees the written value
    valid_i1 = 1; valid_i2 = 1; pc_i1 = 32'hBFC00000; pc_i2 = 32'hBFC00004;
    exceptinfo_i1 = mk(1, 5'd12, 5'd0, 0); rt_rdata_i1 = 32'h0000FF01;
    exceptinfo_i2 = mk(0, 5'd0, 5'd12, 0);
    #1;
    chk("pair_stall", stall_o, 1);
    chk("pair_we", cp0_exceptinfo_o[42], 1);
    tick();
    cp0_rdata_i = 32'h0040FF01;
    #1;
    chk("second_stall", stall_o, 0);
    chk("second_raddr", cp0_exceptinfo_o[36:32], 12);
    chk("second_pc", cp0_pc_o, 32'hBFC00004);
    tick();
    clr();
    #1;
    chk("mfc0_rdata2", rdata_o2, 32'h0040FF01);
    tick();
    // syscall in slot 1 wins over overflow in slot 2
    valid_i1 = 1; valid_i2 = 1; pc_i1 = 32'hBFC00100; pc_i2 = 32'hBFC00104;
    exceptinfo_i1 = mk(0, 0, 0, 32'h8); exceptinfo_i2 = mk(0, 0, 0, 32'hC);
    cp0_flush_i = 1; cp0_new_pc_i = 32'hBFC00380;
    #1;
    chk("sys_pc", cp0_pc_o, 32'hBFC00100);
    chk("sys_stall", stall_o, 0);
    tick();
    clr();
    redirect_ready_i = 1;
    #1;
    chk("sys_redir_pc", redirect_pc_o, 32'hBFC00380);
    tick();
    clr();
    for (int i = 0; i < DRAIN; i++) tick();
    // slot 2 alone excepts, then a slow redirect handshake
    valid_i1 = 1; valid_i2 = 1; pc_i1 = 32'hBFC00200; pc_i2 = 32'hBFC00204;
    exceptinfo_i2 = mk(0, 0, 0, 32'h4); bad_addr_i2 = 32'h13;
    cp0_flush_i = 1; cp0_new_pc_i = 32'hBFC00380;
    #1;
    chk("s2_pc", cp0_pc_o, 32'hBFC00204);
    chk("s2_bad_addr", cp0_bad_addr_o, 32'h13);
    chk("s2_stall", stall_o, 0);
    tick();
    clr();
    rv_cnt = 0; fl_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      redirect_ready_i = (i == 3);
      #1;
      if (redirect_valid_o) rv_cnt++;
      if (flush_o) fl_cnt++;
      tick();
    end
    chk("rv_cycles", 64'(rv_cnt), 4);
    chk("flush_cycles", 64'(fl_cnt), 6);
    // interrupt: zero bundles, EPC from slot 1, later flush pulses ignored
    clr();
    pc_i1 = 32'hBFC00300; cp0_flush_i = 1; cp0_new_pc_i = 32'hBFC00380;
    #1;
    chk("irq_pc", cp0_pc_o, 32'hBFC00300);
    chk("irq_info", cp0_exceptinfo_o, 0);
    tick();
    cp0_new_pc_i = 32'h12345678;
    tick();
    tick();
    #1;
    chk("irq_redir_pc", redirect_pc_o, 32'hBFC00380);
    redirect_ready_i = 1;
    cp0_flush_i = 0;
    tick();
    redirect_ready_i = 0;
    for (int i = 0; i < DRAIN; i++) tick();
    // reset inside SECOND and inside REDIRECT
    valid_i1 = 1; valid_i2 = 1; rt_rdata_i1 = 32'h5;
    exceptinfo_i1 = mk(1, 5'd12, 5'd0, 0); exceptinfo_i2 = mk(0, 0, 5'd12, 0);
    tick();
    rst = 1;
    tick();
    rst = 0; clr();
    #1;
    chk("rst2_info", cp0_exceptinfo_o, 0);
    chk("rst2_flush", flush_o, 0);
    tick();
    cp0_flush_i = 1; cp0_new_pc_i = 32'hBFC00380;
    tick();
    cp0_flush_i = 0;
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("rst3_rv", redirect_valid_o, 0);
    chk("rst3_rpc", redirect_pc_o, 0);
    tick();
    // random traffic
    for (int n = 0; n < 1500; n++) begin
      rst = $urandom_range(0, 63) == 0;
      valid_i1 = 1'($urandom); valid_i2 = 1'($urandom);
      exceptinfo_i1 = rnd_info(); exceptinfo_i2 = rnd_info();
      pc_i1 = $urandom; pc_i2 = $urandom; rt_rdata_i1 = $urandom; rt_rdata_i2 = $urandom;
      bad_addr_i1 = $urandom; bad_addr_i2 = $urandom; cp0_rdata_i = $urandom;
      cp0_flush_i = $urandom_range(0, 7) == 0; cp0_new_pc_i = $urandom;
      redirect_ready_i = 1'($urandom);
      tick();
    end
    rst = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
